data_mem_responder: RTL and testbench

//  Responder end of the CPU MEM-stage load/store interface: accepts one request per transaction and commits stores
//  (SB/SH/SW) into a byte array. Returns loads (LB/LH/LW/LBU/LHU) sign- or zero-extended.

---
 rtl/data_mem_responder.sv | 181 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Byte-addressed data memory with a configurable-latency handshake toward the MEM stage.
// Loads return sign/zero-extended data; stores commit 1, 2 or 4 bytes little-endian.
module data_mem_responder #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [31:0]          address,
    input  logic [31:0]          write_data,
    input  logic [2:0]           funct3,
    output logic [31:0]          read_data,
    output logic                 busy,
    output logic                 ready,
    output logic                 misaligned
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int         DEPTH  = 1 << ADDR_BITS;
    localparam logic [3:0] LAT_M2 = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    logic [7:0] mem [0:DEPTH-1];

    logic [1:0]           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 ready_q, ready_d;
    logic [31:0]          read_data_q, read_data_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [2:0]           funct3_q, funct3_d;
    logic                 store_q, store_d;
    logic                 load_q, load_d;

    logic                 req, align_ok, commit;
    logic [ADDR_BITS-1:0] cur_addr;
    logic [31:0]          cur_wdata;
    logic [2:0]           cur_funct3;
    logic                 cur_store, cur_load;
    logic [3:0]           lane_mask;
    logic [7:0]           rd_byte [0:3];
    logic [ADDR_BITS-1:0] lane_addr [0:3];
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^address[31:ADDR_BITS];
    assign req = mem_read | mem_write;

    always_comb begin
        align_ok = 1'b1;
        case (funct3[1:0])
            2'b00:   align_ok = 1'b1;
            2'b01:   align_ok = ~address[0];
            default: align_ok = (address[1:0] == 2'b00);
        endcase
    end

    // With LATENCY==1 the commit happens on the accepting edge, so use live inputs in IDLE.
    assign cur_addr   = (state_q == S_IDLE) ? address[ADDR_BITS-1:0] : addr_q;
    assign cur_wdata  = (state_q == S_IDLE) ? write_data : wdata_q;
    assign cur_funct3 = (state_q == S_IDLE) ? funct3 : funct3_q;
    assign cur_store  = (state_q == S_IDLE) ? mem_write : store_q;
    assign cur_load   = (state_q == S_IDLE) ? (mem_read & ~mem_write) : load_q;

    always_comb begin
        case (cur_funct3[1:0])
            2'b00:   lane_mask = 4'b0001;
            2'b01:   lane_mask = 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_addr[gi] = cur_addr + ADDR_BITS'(gi);
            assign rd_byte[gi]   = mem[lane_addr[gi]];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        funct3_d   = funct3_q;
        store_d    = store_q;
        load_d     = load_q;
        busy       = 1'b0;
        misaligned = 1'b0;
        commit     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (!align_ok) begin
                        misaligned = 1'b1;
                    end else begin
                        busy     = 1'b1;
                        addr_d   = address[ADDR_BITS-1:0];
                        wdata_d  = write_data;
                        funct3_d = funct3;
                        store_d  = mem_write;
                        load_d   = mem_read & ~mem_write;
                        if (LATENCY == 1) begin
                            state_d = S_DONE;
                            commit  = 1'b1;
                        end else begin
                            cnt_d   = LAT_M2;
                            state_d = S_WAIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                busy = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready_d     = commit;
        read_data_d = read_data_q;
        if (commit && cur_load) begin
            case (cur_funct3)
                3'b000:  read_data_d = {{24{rd_byte[0][7]}}, rd_byte[0]};
                3'b100:  read_data_d = {24'd0, rd_byte[0]};
                3'b001:  read_data_d = {{16{rd_byte[1][7]}}, rd_byte[1], rd_byte[0]};
                3'b101:  read_data_d = {16'd0, rd_byte[1], rd_byte[0]};
                default: read_data_d = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            ready_q     <= 1'b0;
            read_data_q <= 32'd0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            funct3_q    <= 3'd0;
            store_q     <= 1'b0;
            load_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            read_data_q <= read_data_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            funct3_q    <= funct3_d;
            store_q     <= store_d;
            load_q      <= load_d;
        end
    end

    // Storage is not cleared by reset, but a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && commit && cur_store) begin
            for (int k = 0; k < 4; k++) begin
                if (lane_mask[k]) begin
                    mem[lane_addr[k]] <= cur_wdata[8*k +: 8];
                end
            end
        end
    end

    assign ready     = ready_q;
    assign read_data = read_data_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (ADDR_BITS=10, LATENCY=2) with a queue of
// expected read_data values popped at each ready pulse.
module tb_data_mem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [31:0] address, write_data;
    logic [2:0]  funct3;
    logic [31:0] read_data;
    logic        busy, ready, misaligned;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_BITS(10), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .address(address), .write_data(write_data), .funct3(funct3),
        .read_data(read_data), .busy(busy), .ready(ready), .misaligned(misaligned)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] f3);
        mem_read = rd; mem_write = wr; address = a; write_data = d; funct3 = f3;
    endtask

    // Aligned request: checks busy profile, latency and the scoreboard value at ready.
    task automatic txn(input string name, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] f3, input logic [31:0] load_val);
        int          cyc;
        logic        seen;
        logic [31:0] expv;
        expv = (rd && !wr) ? load_val : last_rd;
        exp_q.push_back(expv);
        @(negedge clk);
        drive(rd, wr, a, d, f3);
        #1;
        check({name, " busy@T"}, 32'(busy), 32'd1);
        check({name, " misaligned"}, 32'(misaligned), 32'd0);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (ready) seen = 1'b1;
            else check({name, " busy wait"}, 32'(busy), 32'd1);
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        check({name, " ready seen"}, 32'(seen), 32'd1);
        check({name, " latency"}, 32'(cyc), 32'(LAT));
        check({name, " busy@ready"}, 32'(busy), 32'd0);
        check({name, " read_data"}, read_data, exp_q.pop_front());
        last_rd = expv;
        $display("txn %-10s rd=%0b wr=%0b addr=0x%08h f3=%03b latency=%0d read_data=0x%08h",
                 name, rd, wr, a, f3, cyc, read_data);
    endtask

    task automatic mis(input string name, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] f3);
        @(negedge clk);
        drive(rd, wr, a, d, f3);
        #1;
        check({name, " misaligned"}, 32'(misaligned), 32'd1);
        check({name, " busy"}, 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check({name, " no ready"}, 32'(ready), 32'd0);
            check({name, " read_data held"}, read_data, last_rd);
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        $display("mis %-10s addr=0x%08h f3=%03b misaligned=%0b read_data=0x%08h",
                 name, a, f3, misaligned, read_data);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        last_rd = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset ready", 32'(ready), 32'd0);
        check("reset misaligned", 32'(misaligned), 32'd0);
        check("reset read_data", read_data, 32'd0);
        $display("rst reset released read_data=0x%08h", read_data);
        reset = 1'b0;

        txn("SW10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0);
        txn("LW10", 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF);
        txn("LB13", 1'b1, 1'b0, 32'h13, 32'h0, 3'b000, 32'hFFFFFFDE);
        txn("LBU13", 1'b1, 1'b0, 32'h13, 32'h0, 3'b100, 32'h000000DE);
        txn("LH12", 1'b1, 1'b0, 32'h12, 32'h0, 3'b001, 32'hFFFFDEAD);
        txn("LHU10", 1'b1, 1'b0, 32'h10, 32'h0, 3'b101, 32'h0000BEEF);

        txn("SB11", 1'b0, 1'b1, 32'h11, 32'h12345677, 3'b000, 32'h0);
        txn("SH12", 1'b0, 1'b1, 32'h12, 32'h0000ABCD, 3'b001, 32'h0);
        txn("LW10b", 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 32'hABCD77EF);
        txn("LW410", 1'b1, 1'b0, 32'h410, 32'h0, 3'b010, 32'hABCD77EF);

        mis("LW12", 1'b1, 1'b0, 32'h12, 32'h0, 3'b010);
        mis("SH11", 1'b0, 1'b1, 32'h11, 32'h0000FFFF, 3'b001);
        txn("LW10c", 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 32'hABCD77EF);
        txn("BOTH10", 1'b1, 1'b1, 32'h10, 32'h01020304, 3'b010, 32'h0);
        txn("LW10d", 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 32'h01020304);

        txn("SW20", 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 3'b010, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h20, 32'h11111111, 3'b010);
        #1;
        check("abort busy@T", 32'(busy), 32'd1);
        @(negedge clk);
        check("abort busy wait", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        #1;
        check("abort ready", 32'(ready), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort read_data", read_data, 32'd0);
        @(negedge clk);
        check("abort no late ready", 32'(ready), 32'd0);
        last_rd = 32'd0;
        $display("abt SW20 aborted by reset ready=%0b busy=%0b", ready, busy);
        txn("LW20", 1'b1, 1'b0, 32'h20, 32'h0, 3'b010, 32'hCAFEF00D);

        check("scoreboard empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
